// File: rtl/signed_mul_top_if.sv
// rtl/signed_mul_top_if.sv - operand/product bundle for the signed array multiplier
interface signed_mul_top_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] out;

    modport master (output a, output b, input out);
    modport slave  (input a, input b, output out);
endinterface

// File: rtl/signed_mul_top.sv
// rtl/signed_mul_top.sv - Baugh-Wooley signed array multiplier, WIDTH x WIDTH -> 2*WIDTH
// Optional output register enabled by defining MUL_TOP_OUT_REG_EN.
module signed_mul_top_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ z;
    assign cout = (x & y) | (x & z) | (y & z);
endmodule

module signed_mul_top #(
    parameter int WIDTH = 6
) (
    input  logic clk,
    input  logic rst_n,
    signed_mul_top_if.slave bus
);
    localparam int N = 2 * WIDTH;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [N-1:0]     product;

    assign a = bus.a;
    assign b = bus.b;

    genvar i, k;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_row
            logic [N-1:0] pp_row;
            logic [N-1:0] sum;
            logic [N-1:0] carry;

            // Row 0 never reaches bit WIDTH, so the two correction ones ride in its empty slots.
            for (k = 0; k < N; k++) begin : g_pp
                if (k >= i && k < i + WIDTH) begin : g_term
                    if ((i == WIDTH - 1) != ((k - i) == WIDTH - 1)) begin : g_inv
                        assign pp_row[k] = ~(a[k-i] & b[i]);
                    end else begin : g_pos
                        assign pp_row[k] = a[k-i] & b[i];
                    end
                end else if (i == 0 && (k == WIDTH || k == N - 1)) begin : g_corr
                    assign pp_row[k] = 1'b1;
                end else begin : g_zero
                    assign pp_row[k] = 1'b0;
                end
            end

            if (i == 0) begin : g_init
                assign sum   = pp_row;
                assign carry = '0;
            end else begin : g_csa
                logic [N-1:0] cout_w;
                logic         cout_top_unused;

                for (k = 0; k < N; k++) begin : g_fa
                    signed_mul_top_fa u_fa (
                        .x    (g_row[i-1].sum[k]),
                        .y    (g_row[i-1].carry[k]),
                        .z    (pp_row[k]),
                        .s    (sum[k]),
                        .cout (cout_w[k])
                    );
                end
                assign carry           = {cout_w[N-2:0], 1'b0};
                assign cout_top_unused = cout_w[N-1];
            end
        end
    endgenerate

    // Final ripple carry-propagate adder; the carry out of the MSB wraps away mod 2^N.
    logic [N:0] cpa_c;
    logic       cpa_top_unused;

    assign cpa_c[0] = 1'b0;

    generate
        for (k = 0; k < N; k++) begin : g_cpa
            signed_mul_top_fa u_fa (
                .x    (g_row[WIDTH-1].sum[k]),
                .y    (g_row[WIDTH-1].carry[k]),
                .z    (cpa_c[k]),
                .s    (product[k]),
                .cout (cpa_c[k+1])
            );
        end
    endgenerate

    assign cpa_top_unused = cpa_c[N];

`ifdef MUL_TOP_OUT_REG_EN
    logic [N-1:0] out_d;
    logic [N-1:0] out_q;

    always_comb begin
        out_d = product;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
`else
    logic clk_rst_unused;

    assign clk_rst_unused = clk ^ rst_n;
    assign bus.out        = product;
`endif

endmodule

// File: tb/tb_signed_mul_top.sv
// tb/tb_signed_mul_top.sv - directed and exhaustive checks for signed_mul_top at WIDTH=6 and WIDTH=4
module tb_signed_mul_top;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    signed_mul_top_if #(.WIDTH(6)) bus6 ();
    signed_mul_top_if #(.WIDTH(4)) bus4 ();

    signed_mul_top #(.WIDTH(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    signed_mul_top #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
`ifdef MUL_TOP_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #100;
`endif
    endtask

    int va [9] = '{31, -32, -32, -1, -1, 0, 5, -7, -5};
    int vb [9] = '{31, -32, 31, -1, 31, -32, -7, 5, -7};
    int ve [9] = '{'h3C1, 'h400, 'hC20, 'h001, 'hFE1, 'h000, 'hFDD, 'hFDD, 'h023};

    int sa [4] = '{1, -3, 7, -32};
    int sb [4] = '{2, 4, -8, -1};
    int se [4] = '{'h002, 'hFF4, 'hFC8, 'h020};

    initial begin
        bus6.a = '0;
        bus6.b = '0;
        bus4.a = '0;
        bus4.b = '0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out6", 32'(bus6.out), 32'h0);
        check("reset_out4", 32'(bus4.out), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            bus6.a = 6'(va[i]);
            bus6.b = 6'(vb[i]);
            settle();
            check($sformatf("corner[%0d] %0d*%0d", i, va[i], vb[i]), 32'(bus6.out), 32'(ve[i]));
        end

        for (int x = -32; x < 32; x++) begin
            for (int y = -32; y < 32; y++) begin
                bus6.a = 6'(x);
                bus6.b = 6'(y);
                settle();
                check($sformatf("sweep6 %0d*%0d", x, y), 32'(bus6.out), 32'((x * y) & 'hFFF));
            end
        end

        bus4.a = 4'(-8);
        bus4.b = 4'(-8);
        settle();
        check("w4 -8*-8", 32'(bus4.out), 32'h40);

        for (int x = -8; x < 8; x++) begin
            for (int y = -8; y < 8; y++) begin
                bus4.a = 4'(x);
                bus4.b = 4'(y);
                settle();
                check($sformatf("sweep4 %0d*%0d", x, y), 32'(bus4.out), 32'((x * y) & 'hFF));
            end
        end

`ifdef MUL_TOP_OUT_REG_EN
        bus6.a = 6'd31;
        bus6.b = 6'd31;
        settle();
        bus6.a = 6'(3);
        bus6.b = 6'(-4);
        #1;
        check("lat_hold", 32'(bus6.out), 32'h3C1);
        @(posedge clk);
        #1;
        check("lat_one_edge", 32'(bus6.out), 32'hFF4);

        for (int i = 0; i < 4; i++) begin
            bus6.a = 6'(sa[i]);
            bus6.b = 6'(sb[i]);
            @(posedge clk);
            #1;
            check($sformatf("b2b[%0d]", i), 32'(bus6.out), 32'(se[i]));
        end

        rst_n  = 1'b0;
        bus6.a = 6'd31;
        bus6.b = 6'd31;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold[%0d]", i), 32'(bus6.out), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", 32'(bus6.out), 32'h3C1);

        bus6.a = 6'(5);
        bus6.b = 6'(-7);
        @(posedge clk);
        #1;
        check("mid_before", 32'(bus6.out), 32'hFDD);
        bus6.a = 6'(-5);
        bus6.b = 6'(-7);
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", 32'(bus6.out), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_after", 32'(bus6.out), 32'h023);
`else
        bus6.a = 6'(3);
        bus6.b = 6'(-4);
        rst_n  = 1'b0;
        #100;
        check("comb_ignores_rst", 32'(bus6.out), 32'hFF4);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
